// File: rtl/hazard_scoreboard.sv
// Register scoreboard and IF/ID stall controller for the 5-stage ARM pipeline.
// Define HAZARD_SCOREBOARD_FORWARDING_EN to reduce it to a load-use stall for a forwarding design.
module hazard_scoreboard #(
    parameter int unsigned NREG    = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [3:0]         src1,
    input  logic [3:0]         src2,
    input  logic               Rn_is_valid,
    input  logic               Two_src,
    input  logic               cond_used,
    input  logic               id_wb_en,
    input  logic               id_s,
    input  logic               id_mem_r,
    input  logic [3:0]         Dest,
    input  logic               flush,
    input  logic               writeBackEn,
    input  logic [3:0]         Dest_wb,
    output logic               hazard,
    output logic               freeze,
    output logic [STALL_W-1:0] stall_count,
    output logic               sb_error
);

    logic               issue;
    logic               sr_pending_q;
    logic [STALL_W-1:0] stall_q;

    assign issue       = id_valid & ~hazard & ~flush;
    assign freeze      = hazard;
    assign stall_count = stall_q;

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN

    logic       ld_valid_q;
    logic [3:0] ld_dest_q;
    logic       unused_wb;

    assign unused_wb = writeBackEn ^ (^Dest_wb);
    assign sb_error  = 1'b0;

    // Only a load sitting in EXE cannot be forwarded to the instruction in ID.
    assign hazard = id_valid &
                    ((ld_valid_q & ((Rn_is_valid & (src1 == ld_dest_q)) |
                                    (Two_src & (src2 == ld_dest_q)))) |
                     (cond_used & sr_pending_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_valid_q <= 1'b0;
            ld_dest_q  <= '0;
        end else begin
            ld_valid_q <= issue & id_mem_r & id_wb_en;
            ld_dest_q  <= Dest;
        end
    end

`else

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] pend_q [NREG];
    logic [CNT_W-1:0] pend_d [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             err_q;
    logic             err_d;
    logic             unused_mem_r;

    assign unused_mem_r = id_mem_r;
    assign sb_error     = err_q;

    assign hazard = id_valid &
                    ((Rn_is_valid & (pend_q[src1] != '0)) |
                     (Two_src & (pend_q[src2] != '0)) |
                     (cond_used & sr_pending_q));

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_vec[i] = issue & id_wb_en & (Dest == 4'(i));
            dec_vec[i] = writeBackEn & (Dest_wb == 4'(i));
        end
    end

    // A simultaneous issue and write-back to one register cancel out.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NREG; i++) begin
            pend_d[i] = pend_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                if (pend_q[i] == CntMax) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + CNT_W'(1);
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (pend_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                pend_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

`endif

    // SR is written at the end of EXE, so it is unsettled for one cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_pending_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            sr_pending_q <= issue & id_s;
            if (hazard && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard; a narrow stall counter
// keeps the saturation case short.
module tb_hazard_scoreboard;

    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          Rn_is_valid;
    logic          Two_src;
    logic          cond_used;
    logic          id_wb_en;
    logic          id_s;
    logic          id_mem_r;
    logic [3:0]    Dest;
    logic          flush;
    logic          writeBackEn;
    logic [3:0]    Dest_wb;
    logic          hazard;
    logic          freeze;
    logic [SW-1:0] stall_count;
    logic          sb_error;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic       rnv;
        logic [3:0] s1;
        logic       two;
        logic [3:0] s2;
        logic       cond;
        logic       wb;
        logic       s;
        logic       memr;
        logic [3:0] dest;
        logic       fl;
        logic       wbe;
        logic [3:0] dwb;
        logic       ehz;
        int         est;
        logic       eerr;
    } vec_t;

    vec_t tbl[$];

    hazard_scoreboard #(
        .NREG   (16),
        .CNT_W  (2),
        .STALL_W(SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .src1       (src1),
        .src2       (src2),
        .Rn_is_valid(Rn_is_valid),
        .Two_src    (Two_src),
        .cond_used  (cond_used),
        .id_wb_en   (id_wb_en),
        .id_s       (id_s),
        .id_mem_r   (id_mem_r),
        .Dest       (Dest),
        .flush      (flush),
        .writeBackEn(writeBackEn),
        .Dest_wb    (Dest_wb),
        .hazard     (hazard),
        .freeze     (freeze),
        .stall_count(stall_count),
        .sb_error   (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic vld, input logic rnv, input logic [3:0] s1,
                                input logic two, input logic [3:0] s2, input logic cond,
                                input logic wb, input logic s, input logic memr,
                                input logic [3:0] dest, input logic fl, input logic wbe,
                                input logic [3:0] dwb, input logic ehz, input int est,
                                input logic eerr);
        vec_t v;
        v.rst = 1'b0; v.vld = vld; v.rnv = rnv; v.s1 = s1; v.two = two; v.s2 = s2;
        v.cond = cond; v.wb = wb; v.s = s; v.memr = memr; v.dest = dest; v.fl = fl;
        v.wbe = wbe; v.dwb = dwb; v.ehz = ehz; v.est = est; v.eerr = eerr;
        return v;
    endfunction

    // Drive one cycle's inputs after the falling edge; outputs are sampled 2ns later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; id_valid = v.vld; Rn_is_valid = v.rnv; src1 = v.s1;
        Two_src = v.two; src2 = v.s2; cond_used = v.cond; id_wb_en = v.wb;
        id_s = v.s; id_mem_r = v.memr; Dest = v.dest; flush = v.fl;
        writeBackEn = v.wbe; Dest_wb = v.dwb;
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        vec_t v;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rst = 1'b1;
        apply(v);
        apply(v);
    endtask

    initial begin
        do_reset();
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0)); // LDR R3
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 1, 0, 0, 4, 0, 0, 0, 1, 0, 0)); // load-use
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 1, 0)); // ADD R3
        tbl.push_back(mk(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)); // CMP
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
`else
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset state
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // ADD R1
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 1, 0, 0)); // SUB reads R1
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 1, 1, 1, 2, 0)); // WB R1
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 3, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 3, 0)); // two writes R2
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 3, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 2, 1, 5, 0));
        tbl.push_back(mk(1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6, 0)); // CMP
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7, 0)); // CMP, no cond
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7, 0)); // back-to-back S
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 4, 1, 0, 0, 0, 8, 0)); // flushed R4
        tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 8, 0)); // flushed S
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 8, 0)); // underflow R7
        tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 0, 0, 0, 8, 1));
        tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8, 1)); // hazard under flush
        tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 1)); // bubble in ID
`endif
        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk($sformatf("v%0d hazard", i), 32'(hazard), 32'(tbl[i].ehz));
            chk($sformatf("v%0d freeze", i), 32'(freeze), 32'(tbl[i].ehz));
            chk($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(tbl[i].est));
            chk($sformatf("v%0d sb_error", i), 32'(sb_error), 32'(tbl[i].eerr));
        end

`ifndef HAZARD_SCOREBOARD_FORWARDING_EN
        // Counter ceiling, simultaneous inc/dec, and overflow on R9.
        do_reset();
        chk("reset clears sb_error", 32'(sb_error), 32'd0);
        chk("reset clears stall_count", 32'(stall_count), 32'd0);
        for (int k = 0; k < 3; k++) apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 1, 9, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("inc+dec at max no error", 32'(sb_error), 32'd0);
        apply(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0));
        chk("pend9 full stalls", 32'(hazard), 32'd1);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0));
        apply(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("pend9 one left stalls", 32'(hazard), 32'd1);
        for (int k = 0; k < 3; k++) apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("overflow sets sb_error", 32'(sb_error), 32'd1);
        for (int k = 0; k < 2; k++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0));
        apply(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("overflow holds pend9 at max", 32'(hazard), 32'd1);

        // Reset mid-operation with R9 still pending.
        do_reset();
        apply(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("mid reset clears pend", 32'(hazard), 32'd0);
        chk("mid reset clears sb_error", 32'(sb_error), 32'd0);

        // Stall counter saturation, using R15.
        apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 15, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 20; k++) apply(mk(1, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("R15 reader stalls", 32'(hazard), 32'd1);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("stall_count saturates", 32'(stall_count), 32'd15);
        chk("no error in saturation run", 32'(sb_error), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
